// File: rtl/occ_pkg.sv
// -----------------------------------------------------------------------------
// occ_pkg : shared types, defaults and helper functions for occupancy_zone_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package occ_pkg;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_CAPACITY = 100;
    localparam int DEF_N_DOORS  = 2;
    localparam int DEF_N_BANKS  = 4;
    localparam int DEF_HYST     = 2;
    localparam int DEF_SP_BASE  = 28;
    localparam int DEF_SP_STEP  = 4;
    localparam int DEF_TICK_DIV = 16;
    localparam int DEF_ENERGY_W = 16;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic int th(input int k, input int cap, input int nb);
        return (k * cap) / nb;
    endfunction

    function automatic int level_to_sp(input int lvl, input int base, input int step);
        return (lvl > 1) ? base - step * (lvl - 1) : base;
    endfunction

endpackage

`default_nettype wire

// File: rtl/occ_level_fsm.sv
// -----------------------------------------------------------------------------
// occ_level_fsm : lighting level state machine with downward hysteresis
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module occ_level_fsm
    import occ_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int N_BANKS  = DEF_N_BANKS,
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int HYST     = DEF_HYST,
    parameter int LVL_W    = $clog2(DEF_N_BANKS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    output logic [LVL_W-1:0] level
);

    // The state encoding is the level itself: L0..L_N_BANKS map to 0..N_BANKS.
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    step_e            step;

    always_comb begin
        step = STEP_HOLD;
        for (int k = 0; k <= N_BANKS; k++) begin
            if (int'(level_q) == k) begin
                if (k < N_BANKS && int'(count) > th(k, CAPACITY, N_BANKS))
                    step = STEP_UP;
                else if (k == 1 && count == '0)
                    step = STEP_DOWN;
                else if (k >= 2 && int'(count) + HYST <= th(k - 1, CAPACITY, N_BANKS))
                    step = STEP_DOWN;
            end
        end

        level_d = level_q;
        case (step)
            STEP_UP:   level_d = level_q + LVL_W'(1);
            STEP_DOWN: level_d = level_q - LVL_W'(1);
            default:   level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) level_q <= '0;
        else        level_q <= level_d;
    end

    assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/occupancy_zone_ctrl.sv
// -----------------------------------------------------------------------------
// occupancy_zone_ctrl : multi-door occupancy counter, lighting level, HVAC
// setpoint and energy accumulator for one auditorium zone.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module occupancy_zone_ctrl
    import occ_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int N_DOORS  = DEF_N_DOORS,
    parameter int N_BANKS  = DEF_N_BANKS,
    parameter int HYST     = DEF_HYST,
    parameter int SP_BASE  = DEF_SP_BASE,
    parameter int SP_STEP  = DEF_SP_STEP,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int ENERGY_W = DEF_ENERGY_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_DOORS-1:0]             entry,
    input  logic [N_DOORS-1:0]             leave,
    input  logic [CNT_W-1:0]               cap_limit,
    input  logic                           energy_clr,
    output logic [CNT_W-1:0]               count,
    output logic                           full,
    output logic                           empty,
    output logic                           denied,
    output logic [$clog2(N_BANKS+1)-1:0]   level,
    output logic [4:0]                     setpoint,
    output logic [ENERGY_W-1:0]            energy
);

    localparam int DW    = $clog2(N_DOORS + 1);
    localparam int AW    = CNT_W + DW;
    localparam int LVL_W = $clog2(N_BANKS + 1);
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0]    count_q, count_d;
    logic                denied_q, denied_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [ENERGY_W-1:0] energy_q, energy_d;

    logic [CNT_W-1:0]    lim;
    logic [AW-1:0]       n_in, n_out, after, room, accepted;
    logic                tick;
    logic [ENERGY_W:0]   esum;

    assign lim   = (cap_limit < CNT_W'(CAPACITY)) ? cap_limit : CNT_W'(CAPACITY);
    assign n_in  = AW'(popcount(32'(entry)));
    assign n_out = AW'(popcount(32'(leave)));

    // Leaves are applied before entries so a full zone can swap people in one cycle.
    assign after    = (AW'(count_q) > n_out) ? AW'(count_q) - n_out : '0;
    assign room     = (AW'(lim) > after) ? AW'(lim) - after : '0;
    assign accepted = (n_in < room) ? n_in : room;
    assign count_d  = CNT_W'(after + accepted);
    assign denied_d = (accepted < n_in);

    assign tick    = (presc_q == PS_W'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PS_W'(1);
    assign esum    = {1'b0, energy_q} + (ENERGY_W + 1)'(level);

    always_comb begin
        energy_d = energy_q;
        if (energy_clr)
            energy_d = '0;
        else if (tick)
            energy_d = esum[ENERGY_W] ? '1 : esum[ENERGY_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            denied_q <= 1'b0;
            presc_q  <= '0;
            energy_q <= '0;
        end else begin
            count_q  <= count_d;
            denied_q <= denied_d;
            presc_q  <= presc_d;
            energy_q <= energy_d;
        end
    end

    occ_level_fsm #(
        .CNT_W    (CNT_W),
        .N_BANKS  (N_BANKS),
        .CAPACITY (CAPACITY),
        .HYST     (HYST),
        .LVL_W    (LVL_W)
    ) u_level_fsm (
        .clk   (clk),
        .reset (reset),
        .count (count_q),
        .level (level)
    );

    assign count    = count_q;
    assign full     = (count_q >= lim);
    assign empty    = (count_q == '0);
    assign denied   = denied_q;
    assign setpoint = 5'(level_to_sp(int'(level), SP_BASE, SP_STEP));
    assign energy   = energy_q;

endmodule

`default_nettype wire

// File: tb/tb_occupancy_zone_ctrl.sv
// -----------------------------------------------------------------------------
// tb_occupancy_zone_ctrl : scoreboard bench for occupancy_zone_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_occupancy_zone_ctrl;

    localparam int CAPACITY = 100;
    localparam int N_BANKS  = 4;
    localparam int HYST     = 2;
    localparam int SP_BASE  = 28;
    localparam int SP_STEP  = 4;
    localparam int TICK_DIV = 16;
    localparam int EMAX     = 65535;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, energy_clr;
    logic [1:0] entry, leave;
    logic [7:0] cap_limit;
    logic [7:0] count;
    logic       full, empty, denied;
    logic [2:0] level;
    logic [4:0] setpoint;
    logic [15:0] energy;

    logic       reset2, energy_clr2;
    logic [1:0] entry2, leave2;
    logic [7:0] cap_limit2;
    logic [7:0] count2;
    logic       full2, empty2, denied2;
    logic [2:0] level2;
    logic [4:0] setpoint2;
    logic [15:0] energy2;

    occupancy_zone_ctrl dut (
        .clk(clk), .reset(reset), .entry(entry), .leave(leave),
        .cap_limit(cap_limit), .energy_clr(energy_clr),
        .count(count), .full(full), .empty(empty), .denied(denied),
        .level(level), .setpoint(setpoint), .energy(energy)
    );

    // Fast-tick copy so energy saturation is reachable in a short run.
    occupancy_zone_ctrl #(.TICK_DIV(2)) dut_fast (
        .clk(clk), .reset(reset2), .entry(entry2), .leave(leave2),
        .cap_limit(cap_limit2), .energy_clr(energy_clr2),
        .count(count2), .full(full2), .empty(empty2), .denied(denied2),
        .level(level2), .setpoint(setpoint2), .energy(energy2)
    );

    typedef struct {
        int count; bit full; bit empty; bit denied; int level; int setpoint; int energy;
    } exp_t;

    typedef struct { int n; logic [1:0] en; logic [1:0] lv; int chk_lvl; } ph_t;

    exp_t sb[$];
    int   m_count, m_level, m_energy, m_presc;
    bit   m_denied;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic int th(input int k);
        return (k * CAPACITY) / N_BANKS;
    endfunction

    function automatic logic [34:0] obs_vec();
        return {count, full, empty, denied, level, setpoint, energy};
    endfunction

    function automatic logic [34:0] exp_vec(input exp_t e);
        return {8'(e.count), e.full, e.empty, e.denied, 3'(e.level), 5'(e.setpoint), 16'(e.energy)};
    endfunction

    function automatic string obs_str();
        return $sformatf("cnt=%0d full=%0b empty=%0b den=%0b lvl=%0d sp=%0d en=%0d",
                         count, full, empty, denied, level, setpoint, energy);
    endfunction

    function automatic string exp_str(input exp_t e);
        return $sformatf("cnt=%0d full=%0b empty=%0b den=%0b lvl=%0d sp=%0d en=%0d",
                         e.count, e.full, e.empty, e.denied, e.level, e.setpoint, e.energy);
    endfunction

    // Drive one cycle, advance the behavioural model, queue the expectation.
    task automatic step(input bit rst_n, input logic [1:0] en, input logic [1:0] lv,
                        input int cap, input bit clr);
        exp_t e;
        int n_in, n_out, after, lim, acc, nl, ne;
        reset = rst_n; entry = en; leave = lv; cap_limit = cap[7:0]; energy_clr = clr;
        n_in  = int'(en[0]) + int'(en[1]);
        n_out = int'(lv[0]) + int'(lv[1]);
        lim   = (cap < CAPACITY) ? cap : CAPACITY;
        if (!rst_n) begin
            m_count = 0; m_level = 0; m_energy = 0; m_presc = 0; m_denied = 0;
        end else begin
            nl = m_level;
            if (m_level < N_BANKS && m_count > th(m_level)) nl = m_level + 1;
            else if (m_level == 1 && m_count == 0) nl = 0;
            else if (m_level >= 2 && m_count + HYST <= th(m_level - 1)) nl = m_level - 1;
            ne = m_energy;
            if (clr) ne = 0;
            else if (m_presc == TICK_DIV - 1) ne = (m_energy + m_level > EMAX) ? EMAX : m_energy + m_level;
            m_presc  = (m_presc == TICK_DIV - 1) ? 0 : m_presc + 1;
            after    = (m_count > n_out) ? m_count - n_out : 0;
            acc      = (lim > after) ? ((n_in < lim - after) ? n_in : lim - after) : 0;
            m_count  = after + acc;
            m_denied = (acc < n_in);
            m_level  = nl;
            m_energy = ne;
        end
        e.count = m_count; e.full = (m_count >= lim); e.empty = (m_count == 0);
        e.denied = m_denied; e.level = m_level; e.energy = m_energy;
        e.setpoint = (m_level > 1) ? SP_BASE - SP_STEP * (m_level - 1) : SP_BASE;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) begin
            step(0, 2'b00, 2'b00, 100, 0);
            e = sb.pop_front(); vectors++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL reset_sb: got %s want %s", obs_str(), exp_str(e));
            end
        end
        vectors++;
        if ({count, full, empty, denied, level, setpoint, energy} !== {8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd28, 16'd0}) begin
            miscompares++; $display("FAIL reset_values: got %s want cnt=0 full=0 empty=1 den=0 lvl=0 sp=28 en=0", obs_str());
        end
    endtask

    task automatic test_fill();
        exp_t e;
        for (int i = 0; i < 55; i++) begin
            step(1, 2'b11, 2'b00, 100, 0);
            e = sb.pop_front(); vectors++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL fill_sb cyc%0d: got %s want %s", i, obs_str(), exp_str(e));
            end
            if (i == 49) begin
                vectors++;
                if (count !== 8'd100 || full !== 1'b1 || denied !== 1'b0) begin
                    miscompares++; $display("FAIL fill_reach100: got %s want cnt=100 full=1 den=0", obs_str());
                end
            end
            if (i >= 50) begin
                vectors++;
                if (count !== 8'd100 || denied !== 1'b1) begin
                    miscompares++; $display("FAIL fill_denied cyc%0d: got %s want cnt=100 den=1", i, obs_str());
                end
            end
        end
        vectors++;
        if (level !== 3'd4 || setpoint !== 5'd16) begin
            miscompares++; $display("FAIL fill_level: got lvl=%0d sp=%0d want lvl=4 sp=16", level, setpoint);
        end
    endtask

    task automatic test_drain();
        exp_t e;
        int prev_count, prev_level;
        bit saw_drop;
        prev_count = int'(count); prev_level = int'(level); saw_drop = 0;
        for (int i = 0; i < 60; i++) begin
            step(1, 2'b00, 2'b11, 100, 0);
            e = sb.pop_front(); vectors++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL drain_sb cyc%0d: got %s want %s", i, obs_str(), exp_str(e));
            end
            if (prev_level == 4 && level === 3'd3) begin
                saw_drop = 1; vectors++;
                if (prev_count != 72) begin
                    miscompares++; $display("FAIL drain_4to3: dropped after cnt=%0d want after cnt=72", prev_count);
                end
            end
            prev_count = int'(count); prev_level = int'(level);
        end
        vectors++;
        if (!saw_drop || count !== 8'd0 || empty !== 1'b1 || level !== 3'd0) begin
            miscompares++; $display("FAIL drain_end: drop_seen=%0b got %s want cnt=0 empty=1 lvl=0", saw_drop, obs_str());
        end
    endtask

    task automatic test_hysteresis();
        exp_t e;
        ph_t  ph[$];
        ph = '{'{24, 2'b01, 2'b00, 1}, '{2, 2'b01, 2'b00, 1}, '{2, 2'b00, 2'b00, 2},
               '{2, 2'b00, 2'b01, 2}, '{3, 2'b00, 2'b00, 2}, '{2, 2'b01, 2'b00, 2},
               '{2, 2'b00, 2'b01, 2}, '{2, 2'b01, 2'b00, 2}, '{2, 2'b00, 2'b01, 2},
               '{1, 2'b00, 2'b01, -1}, '{2, 2'b00, 2'b00, 1}};
        foreach (ph[p]) begin
            for (int i = 0; i < ph[p].n; i++) begin
                step(1, ph[p].en, ph[p].lv, 100, 0);
                e = sb.pop_front(); vectors++;
                if (obs_vec() !== exp_vec(e)) begin
                    miscompares++; $display("FAIL hyst_sb ph%0d: got %s want %s", p, obs_str(), exp_str(e));
                end
            end
            if (ph[p].chk_lvl >= 0) begin
                vectors++;
                if (int'(level) != ph[p].chk_lvl) begin
                    miscompares++; $display("FAIL hyst_level ph%0d: got lvl=%0d cnt=%0d want lvl=%0d", p, level, count, ph[p].chk_lvl);
                end
            end
        end
    endtask

    task automatic test_cap_limit();
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            if (i < 13)       step(1, 2'b00, 2'b01, 100, 0);
            else if (i == 13) step(1, 2'b01, 2'b01, 10, 0);
            else if (i < 16)  step(1, 2'b01, 2'b00, 5, 0);
            else if (i < 24)  step(1, 2'b01, 2'b01, 5, 0);
            else              step(1, 2'b11, 2'b00, 0, 0);
            e = sb.pop_front(); vectors++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL cap_sb cyc%0d: got %s want %s", i, obs_str(), exp_str(e));
            end
            if (i == 13 || i == 15 || i == 23 || i == 24) begin
                vectors++;
                if ((i == 13 && (count !== 8'd10 || denied !== 1'b0)) ||
                    (i == 15 && (count !== 8'd10 || denied !== 1'b1 || full !== 1'b1)) ||
                    (i == 23 && (count !== 8'd5  || denied !== 1'b0)) ||
                    (i == 24 && (count !== 8'd5  || denied !== 1'b1 || full !== 1'b1))) begin
                    miscompares++; $display("FAIL cap_point cyc%0d: got %s", i, obs_str());
                end
            end
        end
    endtask

    task automatic test_energy();
        exp_t e;
        int guard;
        for (int i = 0; i < 34; i++) begin
            if (i < 28) step(1, 2'b11, 2'b00, 100, 0);
            else        step(1, 2'b00, 2'b00, 100, 0);
            e = sb.pop_front(); vectors++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL energy_ramp_sb cyc%0d: got %s want %s", i, obs_str(), exp_str(e));
            end
        end
        guard = 0;
        while (m_presc != TICK_DIV - 1 && guard < TICK_DIV) begin
            step(1, 2'b00, 2'b00, 100, 0);
            e = sb.pop_front(); vectors++; guard++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL energy_align_sb: got %s want %s", obs_str(), exp_str(e));
            end
        end
        step(1, 2'b00, 2'b00, 100, 1);
        e = sb.pop_front(); vectors++;
        if (energy !== 16'd0 || obs_vec() !== exp_vec(e)) begin
            miscompares++; $display("FAIL energy_clr_on_tick: got %s want en=0 (%s)", obs_str(), exp_str(e));
        end
        for (int i = 0; i < 64; i++) begin
            step(1, 2'b00, 2'b00, 100, 0);
            e = sb.pop_front(); vectors++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL energy_acc_sb cyc%0d: got %s want %s", i, obs_str(), exp_str(e));
            end
        end
        vectors++;
        if (energy !== 16'd12 || level !== 3'd3 || setpoint !== 5'd20) begin
            miscompares++; $display("FAIL energy_64cyc: got en=%0d lvl=%0d sp=%0d want en=12 lvl=3 sp=20", energy, level, setpoint);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            if (i < 10)       step(1, 2'b00, 2'b11, 100, 0);
            else if (i == 10) step(1, 2'b00, 2'b01, 100, 0);
            else              step(1, 2'b00, 2'b00, 100, 0);
            e = sb.pop_front(); vectors++;
            if (obs_vec() !== exp_vec(e)) begin
                miscompares++; $display("FAIL midrst_pre_sb cyc%0d: got %s want %s", i, obs_str(), exp_str(e));
            end
        end
        vectors++;
        if (count !== 8'd40 || level !== 3'd2 || energy === 16'd0) begin
            miscompares++; $display("FAIL midrst_setup: got %s want cnt=40 lvl=2 en>0", obs_str());
        end
        step(0, 2'b11, 2'b01, 100, 1);
        e = sb.pop_front(); vectors++;
        if ({count, full, empty, denied, level, setpoint, energy} !== {8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd28, 16'd0}) begin
            miscompares++; $display("FAIL midrst_values: got %s want cnt=0 full=0 empty=1 den=0 lvl=0 sp=28 en=0", obs_str());
        end
    endtask

    task automatic test_saturation();
        reset2 = 1'b1; entry2 = 2'b11;
        repeat (50) @(posedge clk);
        #1 entry2 = 2'b00;
        repeat (1000) @(posedge clk);
        #1; vectors++;
        if (energy2 === 16'd0 || energy2 === 16'hFFFF || level2 !== 3'd4) begin
            miscompares++; $display("FAIL sat_midway: got en=%0d lvl=%0d want 0<en<65535 lvl=4", energy2, level2);
        end
        repeat (33000) @(posedge clk);
        #1; vectors++;
        if (energy2 !== 16'hFFFF) begin
            miscompares++; $display("FAIL sat_reached: got en=%0h want ffff", energy2);
        end
        repeat (20) @(posedge clk);
        #1; vectors++;
        if (energy2 !== 16'hFFFF) begin
            miscompares++; $display("FAIL sat_hold: got en=%0h want ffff", energy2);
        end
    endtask

    initial begin
        reset = 1'b0; entry = '0; leave = '0; cap_limit = 8'd100; energy_clr = 1'b0;
        reset2 = 1'b0; entry2 = '0; leave2 = '0; cap_limit2 = 8'd100; energy_clr2 = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_hysteresis();
        test_cap_limit();
        test_energy();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
